// File: rtl/float_pack.sv
// float_pack: multi-cycle IEEE-754 single-precision composer (sign, exponent, raw significand -> packed word + one-hot class).
// Optional macro FLOAT_PACK_RNE_EN enables round-to-nearest-even on pack; default build truncates.
module float_pack #(
  parameter int unsigned EXP_W = 10,
  parameter int          BIAS  = 127
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [23:0]      in_sig,
  input  logic             in_nan,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_float,
  output logic [4:0]       out_class
);

  localparam int unsigned IE_W = EXP_W + 1;
  localparam logic signed [IE_W-1:0] EXP_ONE  = IE_W'(1);
  localparam logic signed [IE_W-1:0] EXP_INF  = IE_W'(255);
  localparam logic signed [IE_W-1:0] EXP_BIAS = IE_W'(BIAS);

  localparam logic [4:0] CLS_ZERO = 5'b00001;
  localparam logic [4:0] CLS_NORM = 5'b00010;
  localparam logic [4:0] CLS_SUB  = 5'b00100;
  localparam logic [4:0] CLS_INF  = 5'b01000;
  localparam logic [4:0] CLS_NAN  = 5'b10000;

  typedef enum logic [1:0] {S_IDLE, S_NORM, S_DENORM, S_DONE} state_t;

  state_t                 r_state;
  logic                   r_sign;
  logic signed [IE_W-1:0] r_exp;     // unbiased in NORM, biased in DENORM
  logic [23:0]            r_sig;
  logic                   r_out_valid;
  logic [31:0]            r_out_float;
  logic [4:0]             r_out_class;

  logic signed [IE_W-1:0] w_bias_exp;
  logic signed [IE_W-1:0] w_norm_exp;
  logic [24:0]            w_sig_r;

`ifdef FLOAT_PACK_RNE_EN
  logic r_guard;
  logic r_sticky;
  logic w_round_up;
`endif

  // Rounded significand and exponent as seen by the pack paths
  always_comb begin
    w_bias_exp = r_exp + EXP_BIAS;
`ifdef FLOAT_PACK_RNE_EN
    w_round_up = r_guard & (r_sticky | r_sig[0]);
    w_sig_r    = {1'b0, r_sig} + 25'(w_round_up);
`else
    w_sig_r    = {1'b0, r_sig};
`endif
    // A carry out of the all-ones mantissa bumps the exponent
    w_norm_exp = w_bias_exp + IE_W'(w_sig_r[24]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_sign      <= 1'b0;
      r_exp       <= '0;
      r_sig       <= '0;
      r_out_valid <= 1'b0;
      r_out_float <= '0;
      r_out_class <= '0;
`ifdef FLOAT_PACK_RNE_EN
      r_guard     <= 1'b0;
      r_sticky    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sign <= in_sign;
            r_exp  <= {in_exp[EXP_W-1], in_exp};
            r_sig  <= in_sig;
`ifdef FLOAT_PACK_RNE_EN
            r_guard  <= 1'b0;
            r_sticky <= 1'b0;
`endif
            if (in_nan) begin
              r_out_float <= {in_sign, 8'hFF, 1'b1, 22'b0};
              r_out_class <= CLS_NAN;
              r_state     <= S_DONE;
            end else if (in_sig == 24'd0) begin
              r_out_float <= {in_sign, 31'b0};
              r_out_class <= CLS_ZERO;
              r_state     <= S_DONE;
            end else begin
              r_state <= S_NORM;
            end
          end
        end

        S_NORM: begin
          if (!r_sig[23]) begin
            r_sig <= r_sig << 1;
            r_exp <= r_exp - EXP_ONE;
          end else if (w_norm_exp >= EXP_INF) begin
            r_out_float <= {r_sign, 8'hFF, 23'b0};
            r_out_class <= CLS_INF;
            r_state     <= S_DONE;
          end else if (w_bias_exp >= EXP_ONE) begin
            r_out_float <= {r_sign, w_norm_exp[7:0], w_sig_r[22:0]};
            r_out_class <= CLS_NORM;
            r_state     <= S_DONE;
          end else begin
            r_exp   <= w_bias_exp;
            r_state <= S_DENORM;
          end
        end

        S_DENORM: begin
          if (r_exp == EXP_ONE) begin
            // Rounding carry into bit 23 lands exactly on the min-normal encoding
            r_out_float <= {r_sign, 7'b0, w_sig_r[23:0]};
            r_out_class <= w_sig_r[23]        ? CLS_NORM :
                           (|w_sig_r[22:0])   ? CLS_SUB  : CLS_ZERO;
            r_state     <= S_DONE;
          end else if (r_sig == 24'd0) begin
            r_out_float <= {r_sign, 31'b0};
            r_out_class <= CLS_ZERO;
            r_state     <= S_DONE;
          end else begin
            r_sig <= r_sig >> 1;
            r_exp <= r_exp + EXP_ONE;
`ifdef FLOAT_PACK_RNE_EN
            r_guard  <= r_sig[0];
            r_sticky <= r_sticky | r_guard;
`endif
          end
        end

        S_DONE: begin
          // out_valid rises one cycle after the result is captured
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign out_float = r_out_float;
  assign out_class = r_out_class;

endmodule
